// File: rtl/rel_compare_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rel_compare_iter_if
//  Description : Request/response bundle for the iterative relational compare
//                unit. Carries the operand request (valid/ready, a, b, op,
//                is_signed) and the result response (valid/ready, result,
//                z, n, op_err).
//  Modports    : master - request producer / result consumer
//                slave  - the compare unit itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface rel_compare_iter_if #(
    parameter int WIDTH = 32
);
    // request channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             is_signed;

    // response channel
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             z;
    logic             n;
    logic             op_err;

    modport master (
        output in_valid, a, b, op, is_signed, out_ready,
        input  in_ready, out_valid, result, z, n, op_err
    );

    modport slave (
        input  in_valid, a, b, op, is_signed, out_ready,
        output in_ready, out_valid, result, z, n, op_err
    );
endinterface
`default_nettype wire

// File: rtl/rel_compare_iter.sv
`default_nettype none
// ============================================================================
//  Module      : rel_compare_iter
//  Description : Iterative multi-mode relational compare (EQ/NE/LT/LE/GT/GE,
//                signed or unsigned). Walks the operands CHUNK bits per cycle
//                from the MSB end, optionally stopping at the first differing
//                chunk, and returns the predicate plus z (a==b) and n (a<b).
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset
//                bus    - rel_compare_iter_if.slave (request + response)
//  Revision    : 1.0 - initial release
// ============================================================================
module rel_compare_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rel_compare_iter_if.slave  bus
);

    localparam int c_n_chunks = WIDTH / CHUNK;
    localparam int c_idx_w    = (c_n_chunks > 1) ? $clog2(c_n_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_n_chunks - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [2:0] c_op_eq = 3'd0;
    localparam logic [2:0] c_op_ne = 3'd1;
    localparam logic [2:0] c_op_lt = 3'd2;
    localparam logic [2:0] c_op_le = 3'd3;
    localparam logic [2:0] c_op_gt = 3'd4;
    localparam logic [2:0] c_op_ge = 3'd5;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;

    // Operands are stored biased and shifted left one chunk per cycle, so the
    // chunk under test is always the top CHUNK bits.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   w_bias;
    logic [2:0]         r_op;
    logic [c_idx_w-1:0] r_idx;
    logic               r_gt;
    logic               r_lt;

    logic               r_result;
    logic               r_z;
    logic               r_n;
    logic               r_op_err;

    logic [CHUNK-1:0]   w_ca;
    logic [CHUNK-1:0]   w_cb;
    logic               w_chunk_gt;
    logic               w_chunk_lt;
    logic               w_fin_gt;
    logic               w_fin_lt;
    logic               w_eq;
    logic               w_last;
    logic               w_finish;
    logic               w_pred;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_accept)      w_next_state = c_st_busy;
            c_st_busy: if (w_finish)      w_next_state = c_st_done;
            c_st_done: if (bus.out_ready) w_next_state = c_st_idle;
            default:                      w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_st_idle: w_in_ready  = 1'b1;
            c_st_done: w_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign w_bias = WIDTH'(bus.is_signed) << (WIDTH - 1);

    // ------------------------------------------------------------------
    // Chunk compare
    // ------------------------------------------------------------------
    assign w_ca       = r_a[WIDTH-1 -: CHUNK];
    assign w_cb       = r_b[WIDTH-1 -: CHUNK];
    assign w_chunk_gt = (w_ca > w_cb);
    assign w_chunk_lt = (w_ca < w_cb);

    // Once a difference has been recorded it dominates every later chunk.
    assign w_fin_gt = (r_gt | r_lt) ? r_gt : w_chunk_gt;
    assign w_fin_lt = (r_gt | r_lt) ? r_lt : w_chunk_lt;
    assign w_eq     = ~w_fin_gt & ~w_fin_lt;

    assign w_last   = (r_idx == c_last_idx);
    assign w_finish = w_last | ((EARLY_EXIT != 0) & (w_chunk_gt | w_chunk_lt));

    always_comb begin
        w_pred = 1'b0;
        case (r_op)
            c_op_eq: w_pred = w_eq;
            c_op_ne: w_pred = ~w_eq;
            c_op_lt: w_pred = w_fin_lt;
            c_op_le: w_pred = w_fin_lt | w_eq;
            c_op_gt: w_pred = w_fin_gt;
            c_op_ge: w_pred = w_fin_gt | w_eq;
            default: w_pred = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_result <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_op_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a   <= bus.a ^ w_bias;
                        r_b   <= bus.b ^ w_bias;
                        r_op  <= bus.op;
                        r_idx <= '0;
                        r_gt  <= 1'b0;
                        r_lt  <= 1'b0;
                    end
                end
                c_st_busy: begin
                    r_a   <= r_a << CHUNK;
                    r_b   <= r_b << CHUNK;
                    r_idx <= r_idx + c_idx_w'(1);
                    r_gt  <= w_fin_gt;
                    r_lt  <= w_fin_lt;
                    if (w_finish) begin
                        r_result <= w_pred;
                        r_z      <= w_eq;
                        r_n      <= w_fin_lt;
                        r_op_err <= r_op[2] & r_op[1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.op_err    = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_rel_compare_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rel_compare_iter
//  Description : Self-checking bench for rel_compare_iter. Two instances
//                (early exit on / off) receive identical requests; each result
//                and latency is compared with a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rel_compare_iter;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rel_compare_iter_if #(.WIDTH(W)) bus_ee ();
    rel_compare_iter_if #(.WIDTH(W)) bus_ce ();

    rel_compare_iter #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1)) dut_ee (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ee)
    );

    rel_compare_iter #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(0)) dut_ce (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ce)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic comparison; latency from the first
    // differing chunk of a^b (bias never changes which bits differ).
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op, input bit sgn,
                                  output bit res, output bit eq, output bit lt,
                                  output bit err, output int k);
        bit gt;
        logic [W-1:0] d;
        eq  = (a == b);
        lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt  = !eq && !lt;
        err = (op >= 3'd6);
        case (op)
            3'd0: res = eq;
            3'd1: res = !eq;
            3'd2: res = lt;
            3'd3: res = lt || eq;
            3'd4: res = gt;
            3'd5: res = gt || eq;
            default: res = 1'b0;
        endcase
        d = a ^ b;
        k = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (((d >> (W - C - C * i)) & {{(W-C){1'b0}}, {C{1'b1}}}) != '0) k = i + 1;
        end
    endfunction

    task automatic drive_req(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op, input bit sgn);
        bus_ee.in_valid = v; bus_ee.a = a; bus_ee.b = b; bus_ee.op = op; bus_ee.is_signed = sgn;
        bus_ce.in_valid = v; bus_ce.a = a; bus_ce.b = b; bus_ce.op = op; bus_ce.is_signed = sgn;
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input bit sgn, input int hold, input bit hold_valid);
        bit e_res, e_eq, e_lt, e_err;
        int e_k;
        int lat_ee;
        int lat_ce;
        model(a, b, op, sgn, e_res, e_eq, e_lt, e_err, e_k);
        @(negedge clk);
        chk({tag, "/ee_in_ready"}, bus_ee.in_ready, 1);
        chk({tag, "/ce_in_ready"}, bus_ce.in_ready, 1);
        drive_req(1'b1, a, b, op, sgn);
        @(negedge clk);
        if (!hold_valid) begin
            bus_ee.in_valid = 1'b0;
            bus_ce.in_valid = 1'b0;
        end
        chk({tag, "/ee_busy_in_ready"}, bus_ee.in_ready, 0);
        chk({tag, "/ce_busy_in_ready"}, bus_ce.in_ready, 0);
        lat_ee = 0;
        lat_ce = 0;
        for (int cyc = 1; cyc <= 20 && (lat_ee == 0 || lat_ce == 0); cyc++) begin
            @(negedge clk);
            if (bus_ee.out_valid && lat_ee == 0) lat_ee = cyc;
            if (bus_ce.out_valid && lat_ce == 0) lat_ce = cyc;
        end
        chk({tag, "/ee_latency"}, lat_ee, e_k);
        chk({tag, "/ce_latency"}, lat_ce, N);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "/ee_valid"},  bus_ee.out_valid, 1);
            chk({tag, "/ee_result"}, bus_ee.result, e_res);
            chk({tag, "/ee_z"},      bus_ee.z, e_eq);
            chk({tag, "/ee_n"},      bus_ee.n, e_lt);
            chk({tag, "/ee_op_err"}, bus_ee.op_err, e_err);
            chk({tag, "/ee_in_rdy"}, bus_ee.in_ready, 0);
            chk({tag, "/ce_valid"},  bus_ce.out_valid, 1);
            chk({tag, "/ce_result"}, bus_ce.result, e_res);
            chk({tag, "/ce_z"},      bus_ce.z, e_eq);
            chk({tag, "/ce_n"},      bus_ce.n, e_lt);
            chk({tag, "/ce_op_err"}, bus_ce.op_err, e_err);
            if (h < hold) @(negedge clk);
        end
        bus_ee.in_valid = 1'b0;
        bus_ce.in_valid = 1'b0;
        bus_ee.out_ready = 1'b1;
        bus_ce.out_ready = 1'b1;
        @(negedge clk);
        bus_ee.out_ready = 1'b0;
        bus_ce.out_ready = 1'b0;
        chk({tag, "/ee_released"}, bus_ee.out_valid, 0);
        chk({tag, "/ce_released"}, bus_ce.out_valid, 0);
        chk({tag, "/ee_idle_rdy"}, bus_ee.in_ready, 1);
        chk({tag, "/ce_idle_rdy"}, bus_ce.in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        drive_req(1'b0, '0, '0, 3'd0, 1'b0);
        bus_ee.out_ready = 1'b0;
        bus_ce.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst/ee_in_ready",  bus_ee.in_ready, 1);
        chk("rst/ee_out_valid", bus_ee.out_valid, 0);
        chk("rst/ee_flags",     {bus_ee.result, bus_ee.z, bus_ee.n, bus_ee.op_err}, 0);
        chk("rst/ce_in_ready",  bus_ce.in_ready, 1);
        chk("rst/ce_out_valid", bus_ce.out_valid, 0);
        chk("rst/ce_flags",     {bus_ce.result, bus_ce.z, bus_ce.n, bus_ce.op_err}, 0);

        // directed cases
        run("eq_one",     32'h00000001, 32'h00000001, 3'd0, 1'b0, 0, 1'b0);
        run("gt_chunk0",  32'h02000000, 32'h01000000, 3'd4, 1'b0, 0, 1'b0);
        run("lt_m1_m2",   32'hFFFFFFFF, 32'hFFFFFFFE, 3'd2, 1'b1, 0, 1'b0);
        run("lt_m1_1_s",  32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b1, 0, 1'b0);
        run("lt_m1_1_u",  32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0, 0, 1'b0);
        run("ge_msb_u",   32'h80000000, 32'h00000000, 3'd5, 1'b0, 0, 1'b0);
        run("ge_msb_s",   32'h80000000, 32'h00000000, 3'd5, 1'b1, 0, 1'b0);
        run("backpress",  32'h12345678, 32'h12345679, 3'd3, 1'b0, 5, 1'b1);
        run("b2b_a",      32'h00FF0000, 32'h00FE0000, 3'd1, 1'b0, 0, 1'b0);
        run("b2b_b",      32'h7FFFFFFF, 32'h80000000, 3'd4, 1'b1, 0, 1'b0);
        run("rsvd_op7",   32'h00000005, 32'h00000005, 3'd7, 1'b0, 0, 1'b0);
        run("rsvd_op6",   32'h00000003, 32'h00000009, 3'd6, 1'b1, 1, 1'b0);

        // reset while both instances are still in BUSY
        @(negedge clk);
        drive_req(1'b1, 32'h00001234, 32'h00001234, 3'd0, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 32'h00001234, 32'h00001234, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst/ee_in_ready", bus_ee.in_ready, 1);
        chk("midrst/ce_in_ready", bus_ce.in_ready, 1);
        chk("midrst/ee_z",        bus_ee.z, 0);
        for (int i = 0; i < 6; i++) begin
            chk("midrst/ee_no_result", bus_ee.out_valid, 0);
            chk("midrst/ce_no_result", bus_ce.out_valid, 0);
            @(negedge clk);
        end

        // randomized requests
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = $urandom;
                default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
            endcase
            run("rand", ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rel_compare_iter.md
Name: rel_compare_iter

Overview:
- Parametrised successor to the 32-bit combinational not-equal comparator: a multi-mode relational compare unit (EQ/NE/LT/LE/GT/GE, signed or unsigned).
- Iterative: compares CHUNK bits per cycle, MSB-first, with optional early exit.
- Uses valid/ready handshakes on input and output; produces the predicate result plus z/n flags for the ALU flag path.
- Sits between operand fetch and the condition/branch logic of the control unit.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle. 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK.
- EARLY_EXIT, 1: 1 = finish on the first differing chunk; 0 = always examine all N chunks (constant latency).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  1  predicate value for op.
- z  out  1  a == b.
- n  out  1  a < b under the selected signedness.
- op_err  out  1  op was reserved (6 or 7).

Behaviour:
- Reset (rst_n low at a posedge):
  - state = IDLE.
  - in_ready = 1 after reset; out_valid, result, z, n, op_err = 0.
  - Internal chunk index and decision registers cleared.
  - Reset mid-operation abandons the request; no result is produced.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch a, b, op, is_signed; chunk index = 0; go to BUSY.
  - Signed bias: if is_signed, the MSB of both latched operands is inverted, after which the compare is unsigned.
- BUSY:
  - in_ready = 0.
  - Each cycle compares chunk bits [WIDTH-1-i*CHUNK -: CHUNK] of the biased operands (i = current index). Index increments each cycle.
  - Chunk differs: record gt/lt.
    - EARLY_EXIT=1: go to DONE at this edge.
    - EARLY_EXIT=0: the first difference is kept and later chunks are ignored.
  - Last chunk (i = N-1) evaluated: go to DONE; chunks equal so far means equal.
- Latency, from the accept edge to out_valid high:
  - k cycles, where k = number of chunks examined.
  - EARLY_EXIT=1: k = 1 + index of the first differing chunk, or N if the operands are equal.
  - EARLY_EXIT=0: k = N always.
- DONE:
  - out_valid = 1; outputs are registered and stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid = 0. The next request can be accepted no earlier than the following edge (no accept/complete overlap).
- Outputs:
  - z = eq.
  - n = lt.
  - result = eq (EQ), !eq (NE), lt (LT), lt|eq (LE), gt (GT), gt|eq (GE).
- Reserved op (6/7): the full compare still runs; result = 0, op_err = 1, z/n valid.
- in_valid while not in IDLE is ignored, since in_ready = 0; the upstream holds its data.
- No combinational path from any input to any output except in_ready/out_valid, which are state decodes.

Test Plan:
- WIDTH=32, CHUNK=8, EARLY_EXIT=1; a=b=0x00000001, op=EQ, unsigned -> out_valid 4 cycles after accept; result=1, z=1, n=0.
- a=0x02000000, b=0x01000000, op=GT, unsigned -> difference in chunk 0; out_valid 1 cycle after accept; result=1, z=0, n=0.
- a=0xFFFFFFFF (-1), b=0xFFFFFFFE (-2), op=LT:
  - signed -> result=0, n=0, latency 4.
  - a=0xFFFFFFFF, b=0x00000001, op=LT, signed -> result=1, n=1; unsigned -> result=0, n=0.
- EARLY_EXIT=0, a=0x80000000, b=0: latency is exactly 4 regardless of operands; op=GE, unsigned -> result=1; signed -> result=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0. Pulse out_ready -> IDLE next cycle. Back-to-back requests are each accepted exactly once.
- Reset and reserved op:
  - rst_n low during BUSY -> next cycle IDLE, out_valid=0, in_ready=1, no stale result.
  - op=7 with a=b=5 -> result=0, op_err=1, z=1.
